// File: rtl/uart_receiver.sv
// UART receive FSM: 2-flop synchronizer, mid-bit sampling of 8N-even-parity-1 frames,
// FIFO write strobe plus one-cycle parity/frame/overrun pulses.
module uart_receiver #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD       = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       receive_wire,
  input  logic       fifo_full,
  output logic       fifo_write,
  output logic [7:0] data_out,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overrun,
  output logic       state_busy
);
  localparam int unsigned CPB  = CLOCK_FREQ / BAUD;
  localparam int unsigned HALF = CPB / 2;
  localparam logic [31:0] CPB_M1  = 32'(CPB - 1);
  localparam logic [31:0] HALF_M1 = 32'(HALF - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [1:0]  sync_q;
  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        wr_q, wr_d;
  logic [7:0]  dout_q, dout_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        rx_s;

  assign rx_s = sync_q[1];

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], receive_wire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      wr_q      <= 1'b0;
      dout_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      wr_q      <= wr_d;
      dout_q    <= dout_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    wr_d      = 1'b0;
    dout_d    = dout_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (cnt_q == CPB_M1) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
      STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is caught on time.
        if (cnt_q == CPB_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s)                 ferr_d = 1'b1;
          else if (^{shift_q, par_q}) perr_d = 1'b1;
          else if (fifo_full)        ovr_d  = 1'b1;
          else begin
            wr_d   = 1'b1;
            dout_d = shift_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign fifo_write   = wr_q;
  assign data_out     = dout_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign overrun      = ovr_q;
  assign state_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clk per bit: frame table plus back-to-back,
// start-glitch and mid-frame reset sequences.
module tb_uart_receiver;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       receive_wire = 1'b1;
  logic       fifo_full = 1'b0;
  logic       fifo_write;
  logic [7:0] data_out;
  logic       parity_error, frame_error, overrun, state_busy;

  uart_receiver #(.CLOCK_FREQ(16), .BAUD(1)) dut (
    .clk(clk), .rst(rst), .receive_wire(receive_wire), .fifo_full(fifo_full),
    .fifo_write(fifo_write), .data_out(data_out), .parity_error(parity_error),
    .frame_error(frame_error), .overrun(overrun), .state_busy(state_busy)
  );

  always #5 clk = ~clk;

  // Pulse/busy counters sampled on the falling edge, away from the active edge.
  int n_wr = 0, n_perr = 0, n_ferr = 0, n_ovr = 0, n_busy = 0;
  logic [7:0] wr_log [0:15];
  always @(negedge clk) begin
    if (fifo_write) begin
      wr_log[n_wr % 16] <= data_out;
      n_wr <= n_wr + 1;
    end
    if (parity_error) n_perr <= n_perr + 1;
    if (frame_error)  n_ferr <= n_ferr + 1;
    if (overrun)      n_ovr  <= n_ovr + 1;
    if (state_busy)   n_busy <= n_busy + 1;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bit_out(input logic b);
    receive_wire = b;
    cyc(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(p);
    bit_out(s);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       full;
    int         exp_wr, exp_perr, exp_ferr, exp_ovr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs [5];
  int w0, p0, f0, o0, b0;

  initial begin
    //            data   par   stop  full  wr perr ferr ovr dout
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 0, 1, 0, 0, 8'hA5};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 8'hA5};
    vecs[3] = '{8'h12, 1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 8'h12};
    vecs[4] = '{8'h7E, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1, 8'h12};

    cyc(3);
    chk("rst_fifo_write", fifo_write, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_parity_error", parity_error, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_state_busy", state_busy, 0);
    rst = 1'b0;
    cyc(5);

    foreach (vecs[i]) begin
      w0 = n_wr; p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
      fifo_full = vecs[i].full;
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      receive_wire = 1'b1;
      cyc(24);
      fifo_full = 1'b0;
      chk($sformatf("v%0d_writes", i), n_wr - w0, vecs[i].exp_wr);
      chk($sformatf("v%0d_parity_err", i), n_perr - p0, vecs[i].exp_perr);
      chk($sformatf("v%0d_frame_err", i), n_ferr - f0, vecs[i].exp_ferr);
      chk($sformatf("v%0d_overrun", i), n_ovr - o0, vecs[i].exp_ovr);
      chk($sformatf("v%0d_data_out", i), data_out, vecs[i].exp_dout);
      chk($sformatf("v%0d_busy_idle", i), state_busy, 0);
    end

    // Back-to-back frames with no idle gap.
    w0 = n_wr; p0 = n_perr; f0 = n_ferr;
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFE, 1'b1, 1'b1);
    receive_wire = 1'b1;
    cyc(24);
    chk("b2b_writes", n_wr - w0, 2);
    chk("b2b_first", wr_log[w0 % 16], 8'h01);
    chk("b2b_second", wr_log[(w0 + 1) % 16], 8'hFE);
    chk("b2b_flags", (n_perr - p0) + (n_ferr - f0), 0);

    // Short low glitch must abort in START.
    w0 = n_wr; p0 = n_perr; f0 = n_ferr; o0 = n_ovr; b0 = n_busy;
    receive_wire = 1'b0;
    cyc(4);
    receive_wire = 1'b1;
    cyc(30);
    chk("glitch_writes", n_wr - w0, 0);
    chk("glitch_flags", (n_perr - p0) + (n_ferr - f0) + (n_ovr - o0), 0);
    chk("glitch_busy_seen", int'((n_busy - b0) > 0), 1);
    chk("glitch_busy_le_9", int'((n_busy - b0) <= 9), 1);
    chk("glitch_busy_idle", state_busy, 0);

    // Reset during data bits of 0x99, then a clean 0x42.
    w0 = n_wr;
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    receive_wire = 1'b0;
    cyc(5);
    rst = 1'b1;
    cyc(2);
    chk("midrst_busy", state_busy, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_fifo_write", fifo_write, 0);
    chk("midrst_flags", int'(parity_error | frame_error | overrun), 0);
    receive_wire = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(24);
    chk("midrst_no_write", n_wr - w0, 0);
    send_frame(8'h42, 1'b0, 1'b1);
    receive_wire = 1'b1;
    cyc(24);
    chk("post_rst_writes", n_wr - w0, 1);
    chk("post_rst_data", data_out, 8'h42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
